masked_sbox_layer_ctrl: RTL

// - Sequences one full 3-share masked S-box layer of the 64-bit LED state through one shared
//   8-bit masked S-box pair (two 4-bit 3-stage PRESENT S-boxes), byte-serially and pipelined.
// - Sits between the LED round controller and the S-box pair. Issues bytes, feeds 90 bits of

---
 rtl/masked_sbox_layer_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/masked_sbox_layer_ctrl.sv
// ---------------------------------------------------------------------------
// masked_sbox_layer_ctrl
//
// Sequences one 3-share masked S-box layer of the 64-bit LED state through a
// single shared 8-bit masked S-box pair, one byte per enabled cycle, with the
// S-box pipeline kept full.
//
// Build option: define SBL_CLEAR_ON_DONE_EN to wipe the output shares and the
// latched input shares on the result handshake, so no share residue is kept.
// Without it, those registers hold their values until the next start.
// Timing and handshake are identical in both builds.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin a layer (sampled only in IDLE)
//   in_s1..in_s3          input shares, captured on an accepted start
//   busy                  high while a layer is running or waiting for pickup
//   out_s1..out_s3        output shares, stable while out_valid
//   out_valid, out_ready  result handshake
//   rnd_in, rnd_valid     fresh randomness from the PRNG
//   rnd_ready             randomness consumed this cycle (same as sb_en)
//   sb_en                 S-box pipeline enable; low freezes every S-box stage
//   sb_r                  randomness to the S-box pair (rnd_in passed through)
//   sb_in1..sb_in3        byte shares to the S-box pair
//   sb_out1..sb_out3      byte shares from the S-box pair
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The result is offered with out_valid (held, with stable data,
// until out_ready). Randomness is offered with rnd_valid and taken when
// rnd_ready is high; rnd_ready depends combinationally on rnd_valid.
// ---------------------------------------------------------------------------
module masked_sbox_layer_ctrl #(
    parameter int SBOX_LAT = 3,
    parameter int NBYTES   = 8,
    parameter int RND_W    = 90
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   in_s1,
    input  logic [8*NBYTES-1:0]   in_s2,
    input  logic [8*NBYTES-1:0]   in_s3,
    output logic                  busy,
    output logic [8*NBYTES-1:0]   out_s1,
    output logic [8*NBYTES-1:0]   out_s2,
    output logic [8*NBYTES-1:0]   out_s3,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [RND_W-1:0]      rnd_in,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic                  sb_en,
    output logic [RND_W-1:0]      sb_r,
    output logic [7:0]            sb_in1,
    output logic [7:0]            sb_in2,
    output logic [7:0]            sb_in3,
    input  logic [7:0]            sb_out1,
    input  logic [7:0]            sb_out2,
    input  logic [7:0]            sb_out3
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = $clog2(NBYTES);
    localparam logic [CW-1:0] NB    = CW'(NBYTES);
    localparam logic [CW-1:0] LASTB = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [8*NBYTES-1:0]   s1, s2, s3;       // latched input shares
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         retire_cnt;
    logic [SBOX_LAT-1:0]   vld;              // which S-box stages hold real bytes

    logic                  issue_live;
    logic [CW-1:0]         next_issue;
    logic [BW-1:0]         next_idx;
    logic [BW-1:0]         ret_idx;

    assign issue_live = (issue_cnt < NB);
    assign next_issue = issue_cnt + CW'(1);
    assign next_idx   = next_issue[BW-1:0];
    assign ret_idx    = retire_cnt[BW-1:0];

    // The S-box pair only advances when fresh randomness is present, so the
    // enable and the randomness acknowledge are the same signal.
    assign sb_en     = (state == RUN) && rnd_valid;
    assign rnd_ready = sb_en;
    assign sb_r      = rnd_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            out_s1     <= '0;
            out_s2     <= '0;
            out_s3     <= '0;
            sb_in1     <= '0;
            sb_in2     <= '0;
            sb_in3     <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            vld        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s1         <= in_s1;
                        s2         <= in_s2;
                        s3         <= in_s3;
                        // Byte 0 is staged now so it is already on sb_in* in
                        // the first RUN cycle.
                        sb_in1     <= in_s1[7:0];
                        sb_in2     <= in_s2[7:0];
                        sb_in3     <= in_s3[7:0];
                        issue_cnt  <= '0;
                        retire_cnt <= '0;
                        vld        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    // Stall cycles (rnd_valid low) leave everything untouched,
                    // which keeps sb_in* and the tracker aligned with the
                    // frozen S-box stages.
                    if (rnd_valid) begin
                        vld <= {vld[SBOX_LAT-2:0], issue_live};
                        if (issue_live) begin
                            issue_cnt <= next_issue;
                            if (next_issue < NB) begin
                                sb_in1 <= s1[{next_idx, 3'b000} +: 8];
                                sb_in2 <= s2[{next_idx, 3'b000} +: 8];
                                sb_in3 <= s3[{next_idx, 3'b000} +: 8];
                            end else begin
                                // Flush cycles push zeros through the pipe.
                                sb_in1 <= '0;
                                sb_in2 <= '0;
                                sb_in3 <= '0;
                            end
                        end
                        if (vld[SBOX_LAT-1]) begin
                            out_s1[{ret_idx, 3'b000} +: 8] <= sb_out1;
                            out_s2[{ret_idx, 3'b000} +: 8] <= sb_out2;
                            out_s3[{ret_idx, 3'b000} +: 8] <= sb_out3;
                            retire_cnt <= retire_cnt + CW'(1);
                            if (retire_cnt == LASTB) begin
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef SBL_CLEAR_ON_DONE_EN
                        out_s1 <= '0;
                        out_s2 <= '0;
                        out_s3 <= '0;
                        s1     <= '0;
                        s2     <= '0;
                        s3     <= '0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
